extamp_rx: RTL and testbench



---
 rtl/extamp_rx.sv | 217 +++++++++++++++++++++
 tb/tb_extamp_rx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/extamp_rx.sv
// extamp_rx: UART receiver and parser for Elecraft "FA<11 digits>;" commands. It outputs the frequency in Hz and the ham-band index.
// Optional inter-byte timeout, enabled by defining EXTAMP_RX_TIMEOUT_EN.
module extamp_rx #(
  parameter int CLKFREQ      = 2500000,
  parameter int BAUDRATE     = 9600,
  parameter bit RX_INVERT    = 1'b1,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rxd,
  output logic [31:0] freq,
  output logic        freq_valid,
  output logic [3:0]  band,
  output logic        frame_err,
  output logic        parse_err,
  output logic        busy
);

  localparam int BITCLKS = CLKFREQ / BAUDRATE;
  localparam int CNT_W   = $clog2(BITCLKS + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BITCLKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BITCLKS / 2 - 1);
  localparam logic LINE_IDLE = 1'b1 ^ RX_INVERT;

  localparam logic [7:0] CH_F    = 8'h46;
  localparam logic [7:0] CH_A    = 8'h41;
  localparam logic [7:0] CH_SEMI = 8'h3B;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_GOT_F, P_DIG, P_SEMI} p_state_t;

  logic             sync1_q, sync2_q, line;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_stb, stop_bad;

  p_state_t         p_state_q, p_state_d;
  logic [3:0]       dig_cnt_q, dig_cnt_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      freq_q, freq_d;
  logic [3:0]       band_q, band_d;
  logic             fv_q, fv_d, perr_q, perr_d, ferr_q;
  logic             bad_byte, is_digit, timeout;
  logic [3:0]       digit;

  function automatic logic [3:0] band_decode(input logic [31:0] f);
    logic [3:0] b;
    b = 4'd0;
    if      (f >= 32'd1800000  && f <= 32'd2000000)  b = 4'd1;
    else if (f >= 32'd3500000  && f <= 32'd4000000)  b = 4'd2;
    else if (f >= 32'd5330000  && f <= 32'd5410000)  b = 4'd3;
    else if (f >= 32'd7000000  && f <= 32'd7300000)  b = 4'd4;
    else if (f >= 32'd10100000 && f <= 32'd10150000) b = 4'd5;
    else if (f >= 32'd14000000 && f <= 32'd14350000) b = 4'd6;
    else if (f >= 32'd18068000 && f <= 32'd18168000) b = 4'd7;
    else if (f >= 32'd21000000 && f <= 32'd21450000) b = 4'd8;
    else if (f >= 32'd24890000 && f <= 32'd24990000) b = 4'd9;
    else if (f >= 32'd28000000 && f <= 32'd29700000) b = 4'd10;
    else if (f >= 32'd50000000 && f <= 32'd54000000) b = 4'd11;
    return b;
  endfunction

  assign line = sync2_q ^ RX_INVERT;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_stb   = 1'b0;
    stop_bad   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!line) rx_state_d = RX_START;
      end
      RX_START: if (cnt_q == HALF_LAST) begin
        cnt_d      = '0;
        bit_idx_d  = 3'd0;
        rx_state_d = line ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == BIT_LAST) begin
        cnt_d     = '0;
        shift_d   = {line, shift_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (cnt_q == BIT_LAST) begin
        cnt_d      = '0;
        rx_state_d = RX_IDLE;
        byte_stb   = line;
        stop_bad   = !line;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign is_digit = (shift_q[7:4] == 4'h3) && (shift_q[3:0] <= 4'd9);
  assign digit    = shift_q[3:0];

  always_comb begin
    p_state_d = p_state_q;
    dig_cnt_d = dig_cnt_q;
    acc_d     = acc_q;
    freq_d    = freq_q;
    band_d    = band_q;
    fv_d      = 1'b0;
    perr_d    = 1'b0;
    bad_byte  = 1'b0;
    if (stop_bad) begin
      p_state_d = P_IDLE;
    end else if (byte_stb) begin
      case (p_state_q)
        P_IDLE: if (shift_q == CH_F) p_state_d = P_GOT_F;
        P_GOT_F: begin
          if (shift_q == CH_A) begin
            p_state_d = P_DIG;
            dig_cnt_d = 4'd0;
            acc_d     = 32'd0;
          end else begin
            bad_byte = 1'b1;
          end
        end
        P_DIG: begin
          // The three leading digits only pad the 11-digit field and must be zero.
          if (!is_digit || (dig_cnt_q < 4'd3 && digit != 4'd0)) begin
            bad_byte = 1'b1;
          end else begin
            if (dig_cnt_q >= 4'd3) acc_d = (acc_q << 3) + (acc_q << 1) + {28'd0, digit};
            dig_cnt_d = dig_cnt_q + 4'd1;
            if (dig_cnt_q == 4'd10) p_state_d = P_SEMI;
          end
        end
        P_SEMI: begin
          if (shift_q == CH_SEMI) begin
            freq_d    = acc_q;
            band_d    = band_decode(acc_q);
            fv_d      = 1'b1;
            p_state_d = P_IDLE;
          end else begin
            bad_byte = 1'b1;
          end
        end
        default: p_state_d = P_IDLE;
      endcase
      if (bad_byte) begin
        perr_d    = 1'b1;
        p_state_d = (shift_q == CH_F) ? P_GOT_F : P_IDLE;
      end
    end else if (timeout) begin
      perr_d    = 1'b1;
      p_state_d = P_IDLE;
    end
  end

`ifdef EXTAMP_RX_TIMEOUT_EN
  localparam int TO_CLKS = TIMEOUT_BITS * BITCLKS;
  localparam int TO_W    = $clog2(TO_CLKS + 1);
  logic [TO_W-1:0] to_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || byte_stb || p_state_q == P_IDLE) to_cnt_q <= '0;
    else                                        to_cnt_q <= to_cnt_q + TO_W'(1);
  end

  assign timeout = (p_state_q != P_IDLE) && (to_cnt_q == TO_W'(TO_CLKS - 1));
`else
  assign timeout = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= LINE_IDLE;
      sync2_q    <= LINE_IDLE;
      rx_state_q <= RX_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      p_state_q  <= P_IDLE;
      dig_cnt_q  <= 4'd0;
      acc_q      <= 32'd0;
      freq_q     <= 32'd0;
      band_q     <= 4'd0;
      fv_q       <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync1_q    <= uart_rxd;
      sync2_q    <= sync1_q;
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      p_state_q  <= p_state_d;
      dig_cnt_q  <= dig_cnt_d;
      acc_q      <= acc_d;
      freq_q     <= freq_d;
      band_q     <= band_d;
      fv_q       <= fv_d;
      perr_q     <= perr_d;
      ferr_q     <= stop_bad;
    end
  end

  assign freq       = freq_q;
  assign band       = band_q;
  assign freq_valid = fv_q;
  assign parse_err  = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (p_state_q != P_IDLE);

endmodule

// File: tb/tb_extamp_rx.sv
// tb_extamp_rx: serializes FA commands into extamp_rx; checks a directed vector table, corner sequences
// and random commands against a positional command-pattern model.
module tb_extamp_rx;

  localparam int CLKFREQ  = 153600;
  localparam int BAUDRATE = 9600;
  localparam int BITCLKS  = CLKFREQ / BAUDRATE;
  localparam bit RX_INV   = 1'b1;

  localparam int BAND_LO [11] = '{1800000, 3500000, 5330000, 7000000, 10100000, 14000000,
                                  18068000, 21000000, 24890000, 28000000, 50000000};
  localparam int BAND_HI [11] = '{2000000, 4000000, 5410000, 7300000, 10150000, 14350000,
                                  18168000, 21450000, 24990000, 29700000, 54000000};

  typedef struct packed {
    logic [127:0] txt;
    logic [7:0]   len;
    logic [31:0]  freq;
    logic [3:0]   band;
    logic [1:0]   n_fv;
    logic [1:0]   n_pe;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rxd = 1'b0;
  logic [31:0] freq;
  logic        freq_valid;
  logic [3:0]  band;
  logic        frame_err, parse_err, busy;

  extamp_rx #(
    .CLKFREQ(CLKFREQ), .BAUDRATE(BAUDRATE), .RX_INVERT(RX_INV), .TIMEOUT_BITS(20)
  ) dut (
    .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .freq(freq), .freq_valid(freq_valid),
    .band(band), .frame_err(frame_err), .parse_err(parse_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_fv = 0, n_pe = 0, n_fe = 0;
  int fv0, pe0, fe0;

  always @(negedge clk) begin
    if (!rst) begin
      if (freq_valid) n_fv++;
      if (parse_err)  n_pe++;
      if (frame_err)  n_fe++;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge, half a cycle away from the sampling edge.
  task automatic drive(input logic lvl, input int n);
    uart_rxd = lvl ^ RX_INV;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    drive(1'b0, BITCLKS);
    for (int i = 0; i < 8; i++) drive(b[i], BITCLKS);
    if (good_stop) drive(1'b1, BITCLKS);
    else begin
      drive(1'b0, BITCLKS * 3 / 4);
      drive(1'b1, BITCLKS / 4 + BITCLKS);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic send_vec(input vec_t v);
    for (int i = 0; i < int'(v.len); i++) send_byte(v.txt[8*(int'(v.len)-1-i) +: 8], 1'b1);
  endtask

  function automatic vec_t mk(input string s, input int f, input int b, input int fv, input int pe);
    vec_t v;
    v = '0;
    for (int i = 0; i < s.len(); i++) v.txt[8*(s.len()-1-i) +: 8] = s[i];
    v.len  = 8'(s.len());
    v.freq = 32'(f);
    v.band = 4'(b);
    v.n_fv = 2'(fv);
    v.n_pe = 2'(pe);
    return v;
  endfunction

  task automatic snap();
    fv0 = n_fv;
    pe0 = n_pe;
    fe0 = n_fe;
  endtask

  // Reference model: progress through the pattern F A 0 0 0 d d d d d d d d ; by position.
  logic [7:0] mq[$];
  logic [7:0] rq[$];
  longint     m_freq;
  int         m_band, m_fv, m_pe;

  function automatic int band_of(input longint f);
    for (int k = 0; k < 11; k++)
      if (f >= BAND_LO[k] && f <= BAND_HI[k]) return k + 1;
    return 0;
  endfunction

  function automatic bit char_ok(input int p, input logic [7:0] c);
    if (p == 0)  return c == 8'h46;
    if (p == 1)  return c == 8'h41;
    if (p <= 4)  return c == 8'h30;
    if (p <= 12) return c >= 8'h30 && c <= 8'h39;
    return c == 8'h3B;
  endfunction

  task automatic model_byte(input logic [7:0] c);
    int p;
    longint f;
    p = mq.size();
    if (char_ok(p, c)) begin
      mq.push_back(c);
      if (mq.size() == 14) begin
        f = 0;
        for (int i = 5; i <= 12; i++) f = f * 10 + (longint'(mq[i]) - 48);
        m_freq = f;
        m_band = band_of(f);
        m_fv++;
        mq.delete();
      end
    end else if (p != 0) begin
      m_pe++;
      mq.delete();
      if (c == 8'h46) mq.push_back(c);
    end
  endtask

  vec_t vecs [16];

  initial begin
    vecs[0]  = mk("FA00014074000;",  14074000,  6, 1, 0);
    vecs[1]  = mk("FA00007000000;",   7000000,  4, 1, 0);
    vecs[2]  = mk("FA00050313000;",  50313000, 11, 1, 0);
    vecs[3]  = mk("FA00012000000;",  12000000,  0, 1, 0);
    vecs[4]  = mk("FA0001407X",      12000000,  0, 0, 1);
    vecs[5]  = mk("FA00003573000;",   3573000,  2, 1, 0);
    vecs[6]  = mk("FA10014074000;",   3573000,  2, 0, 1);
    vecs[7]  = mk("FA00003573000;",   3573000,  2, 1, 0);
    vecs[8]  = mk("FA00001800000;",   1800000,  1, 1, 0);
    vecs[9]  = mk("FA00001799999;",   1799999,  0, 1, 0);
    vecs[10] = mk("FA00054000000;",  54000000, 11, 1, 0);
    vecs[11] = mk("FA00054000001;",  54000001,  0, 1, 0);
    vecs[12] = mk("FFA00014000000;", 14000000,  6, 1, 1);
    vecs[13] = mk("FA00029700000;",  29700000, 10, 1, 0);
    vecs[14] = mk("FA00099999999;",  99999999,  0, 1, 0);
    vecs[15] = mk("xFA00010150000;", 10150000,  5, 1, 0);

    @(negedge clk);
    drive(1'b1, 4);
    check("reset freq", freq, 0);
    check("reset band", band, 0);
    check("reset freq_valid", freq_valid, 0);
    check("reset frame_err", frame_err, 0);
    check("reset parse_err", parse_err, 0);
    check("reset busy", busy, 0);
    rst = 1'b0;
    drive(1'b1, 2 * BITCLKS);

    for (int k = 0; k < 16; k++) begin
      snap();
      send_vec(vecs[k]);
      drive(1'b1, 2 * BITCLKS);
      check($sformatf("vec%0d freq_valid pulses", k), n_fv - fv0, vecs[k].n_fv);
      check($sformatf("vec%0d parse_err pulses", k), n_pe - pe0, vecs[k].n_pe);
      check($sformatf("vec%0d frame_err pulses", k), n_fe - fe0, 0);
      check($sformatf("vec%0d freq", k), freq, vecs[k].freq);
      check($sformatf("vec%0d band", k), band, vecs[k].band);
      check($sformatf("vec%0d busy", k), busy, 0);
    end

    // Bad stop bit mid-command drops the command without a parse error.
    snap();
    send_str("FA000");
    send_byte(8'h31, 1'b0);
    drive(1'b1, 2 * BITCLKS);
    check("framing frame_err pulses", n_fe - fe0, 1);
    check("framing parse_err pulses", n_pe - pe0, 0);
    check("framing freq_valid pulses", n_fv - fv0, 0);
    check("framing busy", busy, 0);
    check("framing freq held", freq, 10150000);
    snap();
    send_str("FA00001840000;");
    drive(1'b1, 2 * BITCLKS);
    check("after framing freq_valid pulses", n_fv - fv0, 1);
    check("after framing freq", freq, 1840000);
    check("after framing band", band, 1);
    check("after framing errors", (n_pe - pe0) + (n_fe - fe0), 0);

    // A short low glitch between bytes must not produce a byte.
    snap();
    send_str("FA0");
    drive(1'b0, 3);
    drive(1'b1, BITCLKS);
    send_str("0014074000;");
    drive(1'b1, 2 * BITCLKS);
    check("glitch freq_valid pulses", n_fv - fv0, 1);
    check("glitch error pulses", (n_pe - pe0) + (n_fe - fe0), 0);
    check("glitch freq", freq, 14074000);

    // Reset in the middle of the 5th digit, then a fresh command.
    send_str("FA0001");
    drive(1'b0, BITCLKS);
    drive(1'b0, BITCLKS / 2);
    check("mid-command busy", busy, 1);
    rst = 1'b1;
    drive(1'b1, 3);
    check("mid reset freq", freq, 0);
    check("mid reset band", band, 0);
    check("mid reset busy", busy, 0);
    rst = 1'b0;
    drive(1'b1, 3 * BITCLKS);
    snap();
    send_str("FA00028074000;");
    drive(1'b1, 2 * BITCLKS);
    check("post reset freq_valid pulses", n_fv - fv0, 1);
    check("post reset freq", freq, 28074000);
    check("post reset band", band, 10);
    check("post reset parse_err pulses", n_pe - pe0, 0);

    // Random commands, some corrupted or prefixed with noise.
    m_freq = 28074000;
    m_band = 10;
    mq.delete();
    for (int r = 0; r < 8; r++) begin
      longint f, t;
      int     k;
      k = int'($urandom_range(0, 10));
      case ($urandom_range(0, 4))
        0:       f = longint'($urandom_range(0, 99999999));
        1:       f = BAND_LO[k];
        2:       f = BAND_HI[k];
        3:       f = BAND_LO[k] - 1;
        default: f = BAND_HI[k] + 1;
      endcase
      rq.delete();
      rq.push_back(8'h46);
      rq.push_back(8'h41);
      for (int i = 0; i < 3; i++) rq.push_back(8'h30);
      t = 10000000;
      for (int i = 0; i < 8; i++) begin
        rq.push_back(8'(48 + (f / t) % 10));
        t = t / 10;
      end
      rq.push_back(8'h3B);
      if ($urandom_range(0, 3) == 0) rq[$urandom_range(0, 13)] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) rq.push_front(8'($urandom_range(0, 255)));
      snap();
      m_fv = 0;
      m_pe = 0;
      for (int i = 0; i < rq.size(); i++) begin
        send_byte(rq[i], 1'b1);
        model_byte(rq[i]);
      end
      drive(1'b1, 2 * BITCLKS);
      check($sformatf("rand%0d freq_valid pulses", r), n_fv - fv0, m_fv);
      check($sformatf("rand%0d parse_err pulses", r), n_pe - pe0, m_pe);
      check($sformatf("rand%0d freq", r), freq, m_freq);
      check($sformatf("rand%0d band", r), band, m_band);
      check($sformatf("rand%0d busy", r), busy, (mq.size() != 0) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
